ad2tx_frame_fifo: RTL and testbench
===================================

// Module: ad2tx_frame_fifo
// PURPOSE
//  Parametrised successor of the 2048x8 ADC-to-TX sample buffer. It buffers ADC samples
//  in an inferred simple-dual-port RAM and releases them to the TX path only as complete
//  frames of FRAME_LEN samples, using a valid/ready stream with a frame-last marker.
//  The write side cannot be stalled; on lack of space a whole frame is dropped and counted.
// PARAMETERS
//  DATA_W    8     sample width
//  ADDR_W    11    RAM address width; DEPTH = 2**ADDR_W
//  FRAME_LEN 256   samples per frame; power of two, 2 <= FRAME_LEN <= DEPTH/2
// PORTS
//  clk          in   1           single clock, all logic rising-edge
//  reset_n      in   1           asynchronous, active-low reset
//  clr          in   1           synchronous flush, 1-cycle pulse
//  in_valid     in   1           ADC sample strobe, no backpressure
//  in_data      in   DATA_W      ADC sample
//  out_valid    out  1           out_data/out_last valid
//  out_ready    in   1           TX accepts; handshake = out_valid & out_ready
//  out_data     out  DATA_W      sample to TX
//  out_last     out  1           high with final sample of a frame
//  frames_avail out  ADDR_W+1    committed frames not yet fully handed over
//  overflow     out  1           sticky: at least one frame dropped since reset/clr
//  drop_cnt     out  16          dropped-frame count, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (reset_n=0, async) and clr (sync): all outputs 0, pointers 0, FSMs to
//    WR_FILL / RD_IDLE. clr beats in_valid and out_ready in the same cycle; a partially
//    written frame and any partially read frame are discarded.
//  - Pointers wr_ptr, commit_ptr, rd_ptr are ADDR_W+1 bits (extra wrap bit);
//    used = commit-side wr_ptr - rd_ptr modulo 2**(ADDR_W+1); addresses wrap naturally.
//  - Write FSM: WR_FILL, WR_DROP. On the first sample of a frame (sample index 0):
//    if DEPTH - (wr_ptr - rd_ptr) >= FRAME_LEN -> WR_FILL, write; else -> WR_DROP, no write,
//    overflow<=1, drop_cnt+=1 (saturating). Index counter counts every in_valid in both
//    states; at index FRAME_LEN-1 it wraps to 0 and the next frame re-evaluates space.
//  - Commit: on the edge writing sample FRAME_LEN-1 in WR_FILL, commit_ptr <= wr_ptr+1 and
//    frames_avail += 1. Dropped frames never commit.
//  - Read FSM: RD_IDLE, RD_FETCH, RD_STREAM. Reads only addresses in [rd_ptr, commit_ptr);
//    RAM read latency 1 cycle; 2-entry output skid buffer gives 1 sample/cycle while
//    out_ready=1, with no bubbles inside or between back-to-back committed frames.
//  - Latency: final sample of a frame written on edge E into an empty FIFO -> out_valid=1
//    after edge E+2.
//  - out_valid, once high, holds with out_data/out_last stable until handshake.
//  - out_last handshake: frames_avail -= 1; simultaneous commit and out_last handshake
//    leaves frames_avail unchanged.
//  - Write and read never target the same address in one cycle; no RAM collision logic.
//  - out_ready low indefinitely: writes continue until space check drops frames; no
//    committed data is ever overwritten.
// TESTING
//  1 Reset: reset_n=0 mid-stream -> all outputs 0 immediately, frames_avail=0.
//  2 One frame (DATA_W=8, FRAME_LEN=256): in_data=0..255, out_ready=1 -> out_valid 2
//    cycles after last write, 256 beats 0..255, out_last only on 255, frames_avail 1->0.
//  3 Backpressure: random out_ready over 4 frames -> data in order, no loss/duplication.
//  4 Overflow: out_ready=0, write 9 frames at DEPTH=2048 -> frames_avail=8, frame 9
//    dropped, overflow=1, drop_cnt=1; release ready -> exactly 8 frames out.
//  5 Wrap: stream 20 frames with continuous out_ready -> pointers wrap, data intact.
//  6 clr mid-frame with in_valid=1 -> next cycle frames_avail=0, out_valid=0, new frame
//    starts at index 0.

Source files
------------

// File: rtl/ad2tx_frame_fifo_if.sv
// Stream bundle between the ADC sample source, the frame FIFO and the TX sink.
// The slave side is the FIFO; the master side is whatever drives samples in
// and accepts frames out.
interface ad2tx_frame_fifo_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/ad2tx_frame_fifo.sv
// Frame-granular ADC-to-TX sample FIFO.
// Samples land in a simple-dual-port RAM; only complete frames are published
// to the reader (commit_ptr). A frame that does not fit when its first sample
// arrives is dropped whole, because the write side cannot be stalled.
// The read side prefetches into a 2-entry skid buffer so the stream runs at
// one sample per cycle with no bubbles while out_ready stays high.
module ad2tx_frame_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  ad2tx_frame_fifo_if.slave bus,
  output logic [ADDR_W:0]   frames_avail,
  output logic              overflow,
  output logic [15:0]       drop_cnt
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam int              IDX_W    = $clog2(FRAME_LEN);
  localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] FRAME_V  = (ADDR_W + 1)'(FRAME_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {WR_FILL, WR_DROP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]   wr_ptr_reg, commit_ptr_reg, rd_ptr_reg;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  wr_state_t         wr_state_reg, wr_state_next;
  rd_state_t         rd_state_reg, rd_state_next;
  logic              rd_pend_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_last_reg;
  logic [1:0]        skid_cnt_reg, skid_cnt_next;
  logic [DATA_W-1:0] skid_data_reg [2];
  logic [DATA_W-1:0] skid_data_next [2];
  logic [1:0]        skid_last_reg, skid_last_next;
  logic [ADDR_W:0]   frames_avail_reg, frames_avail_next;
  logic              overflow_reg;
  logic [15:0]       drop_cnt_reg;

  logic [ADDR_W:0]   used;
  logic              space_ok;
  logic              wr_en, drop, commit;
  logic              pop, rd_en, last_hs;

  // Free space is measured against rd_ptr, so prefetched samples already
  // sitting in the skid buffer free their RAM slots.
  assign used     = wr_ptr_reg - rd_ptr_reg;
  assign space_ok = (DEPTH_V - used) >= FRAME_V;

  // Write FSM: decide fill/drop on the first sample of each frame.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_en         = 1'b0;
    drop          = 1'b0;
    idx_next      = idx_reg;
    if (bus.in_valid && !clr) begin
      idx_next = idx_reg + 1'b1;
      if (idx_reg == '0) begin
        if (space_ok) begin
          wr_state_next = WR_FILL;
          wr_en         = 1'b1;
        end else begin
          wr_state_next = WR_DROP;
          drop          = 1'b1;
        end
      end else if (wr_state_reg == WR_FILL) begin
        wr_en = 1'b1;
      end
    end
  end

  assign commit = wr_en && (idx_reg == IDX_LAST);

  // Read FSM and skid buffer: keep at most two samples owned downstream of the RAM.
  always_comb begin
    pop            = (rd_state_reg == RD_STREAM) && bus.out_ready;
    skid_cnt_next  = skid_cnt_reg + {1'b0, rd_pend_reg} - {1'b0, pop};
    rd_en          = !clr && (rd_ptr_reg != commit_ptr_reg) && (skid_cnt_next < 2'd2);
    skid_data_next = skid_data_reg;
    skid_last_next = skid_last_reg;
    if (pop) begin
      skid_data_next[0] = skid_data_reg[1];
      skid_last_next[0] = skid_last_reg[1];
    end
    if (rd_pend_reg) begin
      if (skid_cnt_next == 2'd1) begin
        skid_data_next[0] = rd_data_reg;
        skid_last_next[0] = rd_last_reg;
      end else begin
        skid_data_next[1] = rd_data_reg;
        skid_last_next[1] = rd_last_reg;
      end
    end
    if (skid_cnt_next != 2'd0) begin
      rd_state_next = RD_STREAM;
    end else if (rd_en) begin
      rd_state_next = RD_FETCH;
    end else begin
      rd_state_next = RD_IDLE;
    end
  end

  // Frame count: a commit and a frame-final handshake in one cycle cancel.
  always_comb begin
    last_hs           = pop && skid_last_reg[0];
    frames_avail_next = frames_avail_reg;
    if (commit && !last_hs) begin
      frames_avail_next = frames_avail_reg + 1'b1;
    end else if (!commit && last_hs) begin
      frames_avail_next = frames_avail_reg - 1'b1;
    end
  end

  // Block RAM: write port at wr_ptr, registered read port at rd_ptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg[ADDR_W-1:0]] <= bus.in_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
    end
  end

  // Control state; clr flushes everything exactly like reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg       <= '0;
      commit_ptr_reg   <= '0;
      rd_ptr_reg       <= '0;
      idx_reg          <= '0;
      wr_state_reg     <= WR_FILL;
      rd_state_reg     <= RD_IDLE;
      rd_pend_reg      <= 1'b0;
      rd_last_reg      <= 1'b0;
      skid_cnt_reg     <= '0;
      skid_data_reg[0] <= '0;
      skid_data_reg[1] <= '0;
      skid_last_reg    <= '0;
      frames_avail_reg <= '0;
      overflow_reg     <= 1'b0;
      drop_cnt_reg     <= '0;
    end else if (clr) begin
      wr_ptr_reg       <= '0;
      commit_ptr_reg   <= '0;
      rd_ptr_reg       <= '0;
      idx_reg          <= '0;
      wr_state_reg     <= WR_FILL;
      rd_state_reg     <= RD_IDLE;
      rd_pend_reg      <= 1'b0;
      rd_last_reg      <= 1'b0;
      skid_cnt_reg     <= '0;
      skid_data_reg[0] <= '0;
      skid_data_reg[1] <= '0;
      skid_last_reg    <= '0;
      frames_avail_reg <= '0;
      overflow_reg     <= 1'b0;
      drop_cnt_reg     <= '0;
    end else begin
      idx_reg       <= idx_next;
      wr_state_reg  <= wr_state_next;
      rd_state_reg  <= rd_state_next;
      rd_pend_reg   <= rd_en;
      skid_cnt_reg  <= skid_cnt_next;
      skid_data_reg <= skid_data_next;
      skid_last_reg <= skid_last_next;
      frames_avail_reg <= frames_avail_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (commit) begin
        commit_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_last_reg <= (rd_ptr_reg[IDX_W-1:0] == IDX_LAST);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 16'hFFFF) begin
          drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign bus.out_valid = (rd_state_reg == RD_STREAM);
  assign bus.out_data  = skid_data_reg[0];
  assign bus.out_last  = skid_last_reg[0];
  assign frames_avail  = frames_avail_reg;
  assign overflow      = overflow_reg;
  assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_ad2tx_frame_fifo.sv
// Directed bench for ad2tx_frame_fifo at DATA_W=8, ADDR_W=11, FRAME_LEN=256.
// Inputs change 1 ns after the rising edge; a negedge monitor records beats.
module tb_ad2tx_frame_fifo;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 11;
  localparam int FRAME_LEN = 256;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clr = 1'b0;
  logic [ADDR_W:0]   frames_avail;
  logic              overflow;
  logic [15:0]       drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rx_data [$];
  logic       rx_last [$];

  ad2tx_frame_fifo_if #(.DATA_W(DATA_W)) bus ();

  ad2tx_frame_fifo #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .bus(bus),
    .frames_avail(frames_avail), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Record every beat that will handshake on the coming rising edge.
  always @(negedge clk) begin
    if (reset_n && !clr && bus.out_valid && bus.out_ready) begin
      rx_data.push_back(bus.out_data);
      rx_last.push_back(bus.out_last);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int t, input int f, input int i);
    return 8'(t * 31 + f * 13 + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_samples(input int t, input int f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pat(t, f, i);
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last: got %0b want 0", bus.out_last); end
    n_cmp++; if (bus.out_data !== 8'd0) begin n_bad++; $display("FAIL reset_out_data: got %0h want 0", bus.out_data); end
    n_cmp++; if (frames_avail !== '0) begin n_bad++; $display("FAIL reset_frames_avail: got %0d want 0", frames_avail); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_one_frame();
    rx_data.delete(); rx_last.delete();
    bus.out_ready = 1'b1;
    write_samples(0, 0, FRAME_LEN);
    n_cmp++; if (frames_avail !== 12'd1) begin n_bad++; $display("FAIL one_frames_avail_commit: got %0d want 1", frames_avail); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL one_latency_e0: got out_valid %0b want 0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL one_latency_e1: got out_valid %0b want 0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd0) begin n_bad++; $display("FAIL one_latency_e2: got valid %0b data %0h want 1 00", bus.out_valid, bus.out_data); end
    repeat (FRAME_LEN) tick();
    n_cmp++; if (rx_data.size() != FRAME_LEN) begin n_bad++; $display("FAIL one_beats_no_bubble: got %0d want %0d", rx_data.size(), FRAME_LEN); end
    n_cmp++; if (frames_avail !== 12'd0) begin n_bad++; $display("FAIL one_frames_avail_end: got %0d want 0", frames_avail); end
    for (int i = 0; i < rx_data.size() && i < FRAME_LEN; i++) begin
      n_cmp++; if (rx_data[i] !== 8'(i) || rx_last[i] !== (i == FRAME_LEN - 1)) begin
        n_bad++; $display("FAIL one_beat[%0d]: got %0h/%0b want %0h/%0b", i, rx_data[i], rx_last[i], 8'(i), (i == FRAME_LEN - 1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic       pv_stall;
    logic [7:0] pv_data;
    logic       pv_last;
    rx_data.delete(); rx_last.delete();
    pv_stall = 1'b0; pv_data = '0; pv_last = 1'b0;
    fork
      for (int f = 0; f < 4; f++) write_samples(1, f, FRAME_LEN);
      for (int c = 0; c < 6000 && rx_data.size() < 4 * FRAME_LEN; c++) begin
        if (pv_stall) begin
          n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== pv_data || bus.out_last !== pv_last) begin
            n_bad++; $display("FAIL bp_hold: got %0b/%0h/%0b want 1/%0h/%0b", bus.out_valid, bus.out_data, bus.out_last, pv_data, pv_last);
          end
        end
        bus.out_ready = 1'($urandom_range(0, 1));
        pv_stall = bus.out_valid && !bus.out_ready;
        pv_data  = bus.out_data;
        pv_last  = bus.out_last;
        tick();
      end
    join
    bus.out_ready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (rx_data.size() != 4 * FRAME_LEN) begin n_bad++; $display("FAIL bp_beats: got %0d want %0d", rx_data.size(), 4 * FRAME_LEN); end
    n_cmp++; if (drop_cnt !== 16'd0 || frames_avail !== 12'd0) begin n_bad++; $display("FAIL bp_status: got drop %0d avail %0d want 0 0", drop_cnt, frames_avail); end
    for (int k = 0; k < rx_data.size() && k < 4 * FRAME_LEN; k++) begin
      n_cmp++; if (rx_data[k] !== pat(1, k / FRAME_LEN, k % FRAME_LEN) || rx_last[k] !== (k % FRAME_LEN == FRAME_LEN - 1)) begin
        n_bad++; $display("FAIL bp_beat[%0d]: got %0h/%0b want %0h/%0b", k, rx_data[k], rx_last[k], pat(1, k / FRAME_LEN, k % FRAME_LEN), (k % FRAME_LEN == FRAME_LEN - 1));
      end
    end
  endtask

  task automatic test_wrap();
    rx_data.delete(); rx_last.delete();
    bus.out_ready = 1'b1;
    for (int f = 0; f < 20; f++) write_samples(2, f, FRAME_LEN);
    for (int c = 0; c < 600 && rx_data.size() < 20 * FRAME_LEN; c++) tick();
    repeat (2) tick();
    n_cmp++; if (rx_data.size() != 20 * FRAME_LEN) begin n_bad++; $display("FAIL wrap_beats: got %0d want %0d", rx_data.size(), 20 * FRAME_LEN); end
    n_cmp++; if (frames_avail !== 12'd0 || drop_cnt !== 16'd0) begin n_bad++; $display("FAIL wrap_status: got avail %0d drop %0d want 0 0", frames_avail, drop_cnt); end
    for (int k = 0; k < rx_data.size() && k < 20 * FRAME_LEN; k++) begin
      n_cmp++; if (rx_data[k] !== pat(2, k / FRAME_LEN, k % FRAME_LEN) || rx_last[k] !== (k % FRAME_LEN == FRAME_LEN - 1)) begin
        n_bad++; $display("FAIL wrap_beat[%0d]: got %0h/%0b want %0h/%0b", k, rx_data[k], rx_last[k], pat(2, k / FRAME_LEN, k % FRAME_LEN), (k % FRAME_LEN == FRAME_LEN - 1));
      end
    end
  endtask

  task automatic test_overflow();
    rx_data.delete(); rx_last.delete();
    bus.out_ready = 1'b0;
    for (int f = 0; f < 9; f++) write_samples(3, f, FRAME_LEN);
    repeat (3) tick();
    n_cmp++; if (frames_avail !== 12'd8) begin n_bad++; $display("FAIL ovf_frames_avail: got %0d want 8", frames_avail); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
    n_cmp++; if (drop_cnt !== 16'd1) begin n_bad++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== pat(3, 0, 0)) begin n_bad++; $display("FAIL ovf_head: got %0b/%0h want 1/%0h", bus.out_valid, bus.out_data, pat(3, 0, 0)); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2600 && rx_data.size() < 8 * FRAME_LEN; c++) tick();
    repeat (20) tick();
    n_cmp++; if (rx_data.size() != 8 * FRAME_LEN) begin n_bad++; $display("FAIL ovf_beats: got %0d want %0d", rx_data.size(), 8 * FRAME_LEN); end
    n_cmp++; if (frames_avail !== 12'd0 || overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_drained: got avail %0d ovf %0b want 0 1", frames_avail, overflow); end
    for (int k = 0; k < rx_data.size() && k < 8 * FRAME_LEN; k++) begin
      n_cmp++; if (rx_data[k] !== pat(3, k / FRAME_LEN, k % FRAME_LEN) || rx_last[k] !== (k % FRAME_LEN == FRAME_LEN - 1)) begin
        n_bad++; $display("FAIL ovf_beat[%0d]: got %0h/%0b want %0h/%0b", k, rx_data[k], rx_last[k], pat(3, k / FRAME_LEN, k % FRAME_LEN), (k % FRAME_LEN == FRAME_LEN - 1));
      end
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b1;
    write_samples(4, 0, FRAME_LEN);
    write_samples(4, 1, 100);
    n_cmp++; if (bus.out_valid !== 1'b1 || overflow !== 1'b1) begin n_bad++; $display("FAIL mid_precondition: got valid %0b ovf %0b want 1 1", bus.out_valid, overflow); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 8'd0) begin n_bad++; $display("FAIL mid_reset_stream: got %0b/%0b/%0h want 0/0/00", bus.out_valid, bus.out_last, bus.out_data); end
    n_cmp++; if (frames_avail !== 12'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_reset_status: got avail %0d ovf %0b drop %0d want 0 0 0", frames_avail, overflow, drop_cnt); end
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_clr();
    rx_data.delete(); rx_last.delete();
    bus.out_ready = 1'b0;
    write_samples(5, 0, FRAME_LEN);
    write_samples(5, 1, 50);
    n_cmp++; if (frames_avail !== 12'd1 || bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL clr_precondition: got avail %0d valid %0b want 1 1", frames_avail, bus.out_valid); end
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (frames_avail !== 12'd0 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_flush: got avail %0d valid %0b want 0 0", frames_avail, bus.out_valid); end
    bus.out_ready = 1'b1;
    write_samples(6, 0, FRAME_LEN);
    repeat (FRAME_LEN + 10) tick();
    n_cmp++; if (rx_data.size() != FRAME_LEN) begin n_bad++; $display("FAIL clr_new_frame_beats: got %0d want %0d", rx_data.size(), FRAME_LEN); end
    for (int i = 0; i < rx_data.size() && i < FRAME_LEN; i++) begin
      n_cmp++; if (rx_data[i] !== pat(6, 0, i) || rx_last[i] !== (i == FRAME_LEN - 1)) begin
        n_bad++; $display("FAIL clr_beat[%0d]: got %0h/%0b want %0h/%0b", i, rx_data[i], rx_last[i], pat(6, 0, i), (i == FRAME_LEN - 1));
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    $display("test_reset done: %0d compared / %0d mismatched", n_cmp, n_bad);
    test_one_frame();
    $display("test_one_frame done: %0d compared / %0d mismatched", n_cmp, n_bad);
    test_backpressure();
    $display("test_backpressure done: %0d compared / %0d mismatched", n_cmp, n_bad);
    test_wrap();
    $display("test_wrap done: %0d compared / %0d mismatched", n_cmp, n_bad);
    test_overflow();
    $display("test_overflow done: %0d compared / %0d mismatched", n_cmp, n_bad);
    test_reset_midstream();
    $display("test_reset_midstream done: %0d compared / %0d mismatched", n_cmp, n_bad);
    test_clr();
    $display("test_clr done: %0d compared / %0d mismatched", n_cmp, n_bad);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
